// File: rtl/speed_pkg.sv
// Shared widths, constants and FSM state type for the wheel-speed front end.
package speed_pkg;

  localparam int unsigned KMH_W    = 7;
  localparam int unsigned PERIOD_W = 12;
  localparam int unsigned NUM_W    = 14;
  localparam int unsigned CIRC_W   = 8;

  // cm per ms to km/h: 1 cm/ms = 36 km/h
  localparam int unsigned M_CM_MS_TO_KMH = 36;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURING  = 1'b1
  } meas_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, NUM_W iterations after load.
module seq_divider #(
  parameter int unsigned NUM_W = 14,
  parameter int unsigned DEN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int unsigned CNT_W = $clog2(NUM_W);

  logic [NUM_W-1:0] work;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_r;
  logic [CNT_W-1:0] iter;
  logic [DEN_W:0]   shifted;
  logic [DEN_W-1:0] diff;
  logic             fits;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shifted = {rem, work[NUM_W-1]};
    fits    = (shifted >= {1'b0, den_r});
    diff    = DEN_W'(shifted - {1'b0, den_r});
  end

  // busy stays high through the done cycle, so a new start lands one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      work  <= '0;
      rem   <= '0;
      den_r <= '0;
      iter  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy  <= 1'b1;
          work  <= num;
          rem   <= '0;
          den_r <= den;
          iter  <= '0;
        end
      end else if (done) begin
        busy <= 1'b0;
      end else begin
        rem  <= fits ? diff : shifted[DEN_W-1:0];
        work <= {work[NUM_W-2:0], fits};
        iter <= iter + 1'b1;
        if (iter == CNT_W'(NUM_W - 1)) begin
          done <= 1'b1;
          quot <= {work[NUM_W-2:0], fits};
        end
      end
    end
  end

endmodule

// File: rtl/speed_calc.sv
// Wheel-pulse period measurement and km/h conversion feeding max_speed and the display.
module speed_calc
  import speed_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1000,
  parameter int unsigned TIMEOUT_MS  = 2000,
  parameter int unsigned LOCKOUT_MS  = 10,
  parameter int unsigned KMH_MAX     = 99
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wheel_pulse,
  input  logic [CIRC_W-1:0] circ_cm,
  output logic [KMH_W-1:0]  kmh,
  output logic              kmh_valid
);

  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

  logic                sync0, sync1, sync2, edge_q;
  logic [TICK_W-1:0]   presc;
  logic                tick;
  logic [PERIOD_W-1:0] period, period_inc;
  meas_state_e         state, state_nxt;
  logic                accept, req, timeout;
  logic                pend_valid, discard;
  logic [PERIOD_W-1:0] pend_p;
  logic                div_start, div_busy, div_done;
  logic [NUM_W-1:0]    div_num, div_quot;
  logic [PERIOD_W-1:0] div_den;
  logic [KMH_W-1:0]    kmh_sat;

  // Two-flop synchroniser plus registered rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync0  <= wheel_pulse;
      sync1  <= sync0;
      sync2  <= sync1;
      edge_q <= sync1 & ~sync2;
    end
  end

  assign tick = (presc == TICK_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Counting the tick of the accept cycle makes P the exact tick count between accepts
  assign period_inc = (tick && (period != PERIOD_W'(TIMEOUT_MS))) ? period + 1'b1 : period;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       period <= '0;
    else if (accept) period <= '0;
    else             period <= period_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req       = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      WAIT_FIRST: begin
        if (edge_q) begin
          accept    = 1'b1;
          state_nxt = MEASURING;
        end
      end
      MEASURING: begin
        if (edge_q && (period_inc >= PERIOD_W'(LOCKOUT_MS))) begin
          accept = 1'b1;
          req    = 1'b1;
        end else if (period == PERIOD_W'(TIMEOUT_MS)) begin
          timeout   = 1'b1;
          state_nxt = WAIT_FIRST;
        end
      end
      default: state_nxt = WAIT_FIRST;
    endcase
  end

  // A fresh request takes priority over (and supersedes) the pending one
  always_comb begin
    div_start = !div_busy && !timeout && (req || pend_valid);
    div_den   = req ? period_inc : pend_p;
    div_num   = NUM_W'(circ_cm) * NUM_W'(M_CM_MS_TO_KMH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_p     <= '0;
    end else if (timeout) begin
      pend_valid <= 1'b0;
    end else if (req && div_busy) begin
      pend_valid <= 1'b1;
      pend_p     <= period_inc;
    end else if (div_start) begin
      pend_valid <= 1'b0;
    end
  end

  // Marks an in-flight division as aborted so its result is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          discard <= 1'b0;
    else if (timeout)   discard <= 1'b1;
    else if (div_start) discard <= 1'b0;
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (PERIOD_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  assign kmh_sat = (div_quot > NUM_W'(KMH_MAX)) ? KMH_W'(KMH_MAX) : div_quot[KMH_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kmh       <= '0;
      kmh_valid <= 1'b0;
    end else begin
      kmh_valid <= 1'b0;
      if (timeout) begin
        kmh       <= '0;
        kmh_valid <= 1'b1;
      end else if (div_done && !discard) begin
        kmh       <= kmh_sat;
        kmh_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_speed_calc.sv
// Directed bench for speed_calc with a 10-cycle ms tick.
module tb_speed_calc;

  logic       clk;
  logic       reset;
  logic       wheel_pulse;
  logic [7:0] circ_cm;
  logic [6:0] kmh;
  logic       kmh_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int circ;
    int gap;
    int exp_n;
    int exp_kmh;
  } vec_t;

  vec_t tbl[8];

  speed_calc #(
    .TICK_CYCLES (10),
    .TIMEOUT_MS  (2000),
    .LOCKOUT_MS  (10),
    .KMH_MAX     (99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wheel_pulse (wheel_pulse),
    .circ_cm     (circ_cm),
    .kmh         (kmh),
    .kmh_valid   (kmh_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Raise wheel_pulse for 20 cycles, run gap cycles in total and record kmh_valid strobes
  task automatic edge_gap(input int gap, output int nval, output int first_cyc, output int first_kmh);
    nval      = 0;
    first_cyc = -1;
    first_kmh = -1;
    wheel_pulse = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk); #1;
      if (i == 20) wheel_pulse = 1'b0;
      if (kmh_valid) begin
        if (nval == 0) begin
          first_cyc = i;
          first_kmh = int'(kmh);
        end
        nval++;
      end
    end
  endtask

  int nv, fc, fk;

  initial begin
    tbl[0] = '{circ: 200, gap: 1440, exp_n: 0, exp_kmh: 0};
    tbl[1] = '{circ: 200, gap: 1450, exp_n: 1, exp_kmh: 50};
    tbl[2] = '{circ: 200, gap: 720,  exp_n: 1, exp_kmh: 49};
    tbl[3] = '{circ: 200, gap: 360,  exp_n: 1, exp_kmh: 99};
    tbl[4] = '{circ: 200, gap: 1000, exp_n: 1, exp_kmh: 99};
    tbl[5] = '{circ: 0,   gap: 930,  exp_n: 1, exp_kmh: 0};
    tbl[6] = '{circ: 255, gap: 1440, exp_n: 1, exp_kmh: 98};
    tbl[7] = '{circ: 200, gap: 50,   exp_n: 1, exp_kmh: 50};

    reset       = 1'b1;
    wheel_pulse = 1'b0;
    circ_cm     = 8'd200;
    repeat (3) @(posedge clk);
    #1;
    check("reset_kmh", int'(kmh), 0);
    check("reset_valid", int'(kmh_valid), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_valid", int'(kmh_valid), 0);

    // Periodic edges: first edge silent, then one strobe per edge 16 cycles after acceptance
    for (int r = 0; r < 8; r++) begin
      circ_cm = 8'(tbl[r].circ);
      edge_gap(tbl[r].gap, nv, fc, fk);
      check($sformatf("row%0d_nvalid", r), nv, tbl[r].exp_n);
      if (tbl[r].exp_n == 1) begin
        check($sformatf("row%0d_latency", r), fc, 19);
        check($sformatf("row%0d_kmh", r), fk, tbl[r].exp_kmh);
        check($sformatf("row%0d_kmh_hold", r), int'(kmh), tbl[r].exp_kmh);
      end
    end

    // Bounce 5 ms after an accepted edge, next edge 144 ms after that accepted edge
    edge_gap(1390, nv, fc, fk);
    check("bounce_nvalid", nv, 0);
    edge_gap(30, nv, fc, fk);
    check("after_bounce_nvalid", nv, 1);
    check("after_bounce_latency", fc, 19);
    check("after_bounce_kmh", fk, 50);

    // No edges: timeout forces a single kmh=0 strobe about 2000 ms after the last accept
    nv = 0; fc = -1; fk = -1;
    for (int i = 1; i <= 21000; i++) begin
      @(posedge clk); #1;
      if (kmh_valid) begin
        if (nv == 0) begin
          fc = 30 + i;
          fk = int'(kmh);
        end
        nv++;
      end
      if (fc >= 0 && (30 + i) > fc + 100) break;
    end
    check("timeout_nvalid", nv, 1);
    check("timeout_kmh", fk, 0);
    check_range("timeout_cycle", fc, 19990, 20010);
    check("timeout_kmh_hold", int'(kmh), 0);

    edge_gap(1000, nv, fc, fk);
    check("rearm_first_nvalid", nv, 0);
    edge_gap(200, nv, fc, fk);
    check("rearm_second_nvalid", nv, 1);
    check("rearm_second_latency", fc, 19);
    check("rearm_second_kmh", fk, 72);

    // Reset while a division is in flight
    wheel_pulse = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    wheel_pulse = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midreset_kmh%0d", i), int'(kmh), 0);
      check($sformatf("midreset_valid%0d", i), int'(kmh_valid), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("release_kmh", int'(kmh), 0);
    check("release_valid", int'(kmh_valid), 0);
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (kmh_valid) nv++;
    end
    check("aborted_result_nvalid", nv, 0);
    check("aborted_result_kmh", int'(kmh), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
